hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Each cycle it generates the enable, stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three conditions: load-use hazards, taken branches resolved in MEM, and data-memory wait states. It also keeps a memory-wait watchdog and saturating performance counters.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard detection
// inputs from ID/EX/MEM and the per-stage enable/stall/flush controls.
interface hazard_ctrl_if;
  // Hazard inputs
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  // Pipeline register controls
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       ex_mem_flush;
  logic       mem_wb_bubble;

  // Pipeline side: drives hazard inputs, consumes controls
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_bubble
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           mem_branch_taken, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_en, ex_mem_flush, mem_wb_bubble
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: load-use stalls,
// branch flushes, dmem wait freezes, a memory-wait watchdog and saturating
// performance counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,      // synchronous, active-low
  hazard_ctrl_if.slave     io_hz,
  input  logic             i_perf_clr,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WcntW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WcntW-1:0] TimeoutCnt = WcntW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  typedef enum logic [1:0] {StRun, StMemWait, StFault} state_e;

  state_e           r_state;
  logic [WcntW-1:0] r_wcnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_mem_err;

  logic             w_fault;
  logic             w_wait;
  logic             w_load_use;
  logic             w_freeze;
  logic             w_flush;
  logic             w_lu_stall;
  logic [WcntW-1:0] w_wcnt_inc;

  assign w_fault    = (r_state == StFault);
  assign w_wait     = io_hz.dmem_req & ~io_hz.dmem_ready;
  assign w_load_use = io_hz.ex_mem_read & (io_hz.ex_rt != 5'd0) &
                      ((io_hz.ex_rt == io_hz.id_rs) |
                       (io_hz.id_uses_rt & (io_hz.ex_rt == io_hz.id_rt)));

  // Priority: fault/wait freeze, then branch flush, then load-use.
  assign w_freeze   = w_fault | w_wait;
  assign w_flush    = ~w_freeze & io_hz.mem_branch_taken;
  assign w_lu_stall = ~w_freeze & ~io_hz.mem_branch_taken & w_load_use;
  // wcnt is 0 in RUN, so this yields 1 on the first wait cycle.
  assign w_wcnt_inc = r_wcnt + WcntW'(1);

  // Decode pipeline controls; defaults apply while reset is held low.
  always_comb begin
    io_hz.pc_en         = 1'b1;
    io_hz.if_id_en      = 1'b1;
    io_hz.if_id_flush   = 1'b0;
    io_hz.id_ex_stall   = 1'b0;
    io_hz.id_ex_flush   = 1'b0;
    io_hz.ex_mem_en     = 1'b1;
    io_hz.ex_mem_flush  = 1'b0;
    io_hz.mem_wb_bubble = 1'b0;
    if (i_reset) begin
      if (w_freeze) begin
        io_hz.pc_en         = 1'b0;
        io_hz.if_id_en      = 1'b0;
        io_hz.id_ex_stall   = 1'b1;
        io_hz.ex_mem_en     = 1'b0;
        io_hz.mem_wb_bubble = 1'b1;
      end else if (w_flush) begin
        io_hz.if_id_flush  = 1'b1;
        io_hz.id_ex_flush  = 1'b1;
        io_hz.ex_mem_flush = 1'b1;
      end else if (w_lu_stall) begin
        io_hz.pc_en       = 1'b0;
        io_hz.if_id_en    = 1'b0;
        io_hz.id_ex_flush = 1'b1;
      end
    end
  end

  // State, watchdog, sticky fault and counters; FAULT holds everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= StRun;
      r_wcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else if (!w_fault) begin
      if (w_wait) begin
        r_wcnt <= w_wcnt_inc;
        if (w_wcnt_inc == TimeoutCnt) begin
          r_state   <= StFault;
          r_mem_err <= 1'b1;
        end else begin
          r_state <= StMemWait;
        end
      end else begin
        r_state <= StRun;
        r_wcnt  <= '0;
      end

      if (i_perf_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else begin
        if ((w_wait | w_lu_stall) && (r_stall_cnt != CntMax)) begin
          r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        if (w_flush && (r_flush_cnt != CntMax)) begin
          r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_mem_err   = r_mem_err;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model built from the pipeline rules.
module tb_hazard_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          perf_clr;
  logic          mem_err;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  hazard_ctrl_if hz ();

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MEM_TIMEOUT(MT),
    .CNT_W      (CW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .io_hz      (hz.slave),
    .i_perf_clr (perf_clr),
    .o_mem_err  (mem_err),
    .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int m_waits = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_fault = 0;
  bit m_err   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_load_use();
    int ert, rs, rt;
    ert = int'(hz.ex_rt);
    rs  = int'(hz.id_rs);
    rt  = int'(hz.id_rt);
    return hz.ex_mem_read && ert != 0 && (ert == rs || (hz.id_uses_rt && ert == rt));
  endfunction

  function automatic bit model_wait();
    return hz.dmem_req && !hz.dmem_ready;
  endfunction

  // {pc_en, if_id_en, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_bubble}
  function automatic logic [7:0] exp_ctrl();
    if (!reset)                   return 8'b1100_0100;
    if (m_fault || model_wait())  return 8'b0001_0001;
    if (hz.mem_branch_taken)      return 8'b1110_1110;
    if (model_load_use())         return 8'b0000_1100;
    return 8'b1100_0100;
  endfunction

  task automatic model_update();
    bit wt, br, lu;
    wt = model_wait();
    br = hz.mem_branch_taken;
    lu = model_load_use();
    if (!reset) begin
      m_waits = 0; m_stall = 0; m_flush = 0; m_fault = 0; m_err = 0;
    end else if (!m_fault) begin
      if (wt) begin
        m_waits++;
        if (m_waits >= MT) begin
          m_fault = 1;
          m_err   = 1;
        end
      end else begin
        m_waits = 0;
      end
      if (perf_clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (wt || (lu && !br)) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
        if (br && !wt)         m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
      end
    end
  endtask

  // Check mid-cycle, then advance the model on the edge; returns just after it.
  task automatic cycle();
    @(negedge clk);
    check("ctrl", 16'({hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_stall,
                       hz.id_ex_flush, hz.ex_mem_en, hz.ex_mem_flush, hz.mem_wb_bubble}),
          16'(exp_ctrl()));
    check("mem_err", 16'(mem_err), 16'(m_err));
    check("stall_cnt", 16'(stall_cnt), 16'(m_stall));
    check("flush_cnt", 16'(flush_cnt), 16'(m_flush));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rt = 5'd0; hz.mem_branch_taken = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    perf_clr = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses);
    hz.ex_mem_read = 1'b1; hz.ex_rt = ert; hz.id_rs = rs; hz.id_rt = rt;
    hz.id_uses_rt = uses;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // Load-use on rs, then ex_rt=0 must not stall
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    cycle();
    check("lu_cnt_one", 16'(stall_cnt), 16'd1);
    idle(); cycle();
    set_lu(5'd0, 5'd0, 5'd0, 1'b1);
    cycle();
    check("lu_rt0_cnt", 16'(stall_cnt), 16'd1);

    // id_uses_rt gating
    idle(); set_lu(5'd7, 5'd3, 5'd7, 1'b0); cycle();
    set_lu(5'd7, 5'd3, 5'd7, 1'b1); cycle();
    check("uses_rt_cnt", 16'(stall_cnt), 16'd2);

    // Branch together with load-use: flush only
    set_lu(5'd5, 5'd5, 5'd0, 1'b0); hz.mem_branch_taken = 1'b1;
    cycle();
    check("br_flush_cnt", 16'(flush_cnt), 16'd1);
    check("br_stall_cnt", 16'(stall_cnt), 16'd2);

    // Three-cycle memory wait
    idle(); perf_clr = 1'b1; cycle();
    idle(); hz.dmem_req = 1'b1;
    repeat (3) cycle();
    hz.dmem_ready = 1'b1; cycle();
    check("wait3_cnt", 16'(stall_cnt), 16'd3);
    idle(); cycle();

    // Saturation and perf_clr precedence
    set_lu(5'd9, 5'd9, 5'd0, 1'b0);
    repeat (20) cycle();
    check("sat_cnt", 16'(stall_cnt), 16'(CMAX));
    perf_clr = 1'b1; cycle();
    check("clr_cnt", 16'(stall_cnt), 16'd0);

    // Watchdog into FAULT, ready ignored, reset recovers
    idle(); hz.dmem_req = 1'b1;
    repeat (6) cycle();
    check("wd_err", 16'(mem_err), 16'd1);
    hz.dmem_ready = 1'b1; perf_clr = 1'b1;
    repeat (2) cycle();
    check("wd_err_held", 16'(mem_err), 16'd1);
    check("wd_cnt_held", 16'(stall_cnt), 16'd4);
    reset = 1'b0; cycle();
    reset = 1'b1; idle(); cycle();
    check("rst_err", 16'(mem_err), 16'd0);
    check("rst_cnt", 16'(stall_cnt), 16'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset              = ($urandom_range(0, 39) != 0);
      perf_clr           = ($urandom_range(0, 19) == 0);
      hz.id_rs           = 5'($urandom_range(0, 3));
      hz.id_rt           = 5'($urandom_range(0, 3));
      hz.id_uses_rt      = 1'($urandom_range(0, 1));
      hz.ex_mem_read     = 1'($urandom_range(0, 1));
      hz.ex_rt           = 5'($urandom_range(0, 3));
      hz.mem_branch_taken = ($urandom_range(0, 5) == 0);
      hz.dmem_req        = ($urandom_range(0, 2) == 0);
      hz.dmem_ready      = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
